// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, one-cycle done pulse.
// Divide-by-zero bypasses the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, divisor_reg};
    if (!trial[WIDTH]) begin
      r_next = trial;
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift;
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              divisor_reg <= divisor;
              r_reg       <= '0;
              q_reg       <= dividend;
              count_reg   <= CW'(WIDTH);
              busy        <= 1'b1;
              state_reg   <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_reg   <= DONE;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          r_reg     <= r_next;
          q_reg     <= q_next;
          count_reg <= count_reg - 1'b1;
          if (count_reg == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_reg   <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
